osr_fifo: RTL and testbench
===========================

OSR_FIFO -- requirements
Module: osr_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: OSR and FIFO word width, 8..32.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port wr_data  in  DATA_W: FIFO write data.
REQ-006 SHALL have port wr_valid  in  1: write request.
REQ-007 SHALL have port wr_ready  out  1: FIFO not full.
REQ-008 SHALL have port fifo_level  out  $clog2(DEPTH)+1: occupied entries.
REQ-009 SHALL have port shift_en  in  1: shift request.
REQ-010 SHALL have port shift_count  in  $clog2(DATA_W): bits per shift; 0 means DATA_W.
REQ-011 SHALL have port shiftdir  in  1: 1 = right (LSB first), 0 = left (MSB first).
REQ-012 SHALL have port autopull  in  1: automatic refill enable.
REQ-013 SHALL have port pull_thresh  in  $clog2(DATA_W): autopull threshold; 0 means DATA_W.
REQ-014 SHALL have port pull_req  in  1: explicit pull.
REQ-015 SHALL have port pull_block  in  1: explicit pull stalls when FIFO is empty.
REQ-016 SHALL have port mov_en  in  1: load OSR from mov_in.
REQ-017 SHALL have port mov_in  in  DATA_W: mov source; also non-blocking empty-pull fallback.
REQ-018 SHALL have port data_out  out  DATA_W: last shifted-out bits, right-justified, zero-extended; registered.
REQ-019 SHALL have port osr  out  DATA_W: OSR contents.
REQ-020 SHALL have port shift_counter  out  $clog2(DATA_W)+1: bits consumed, 0..DATA_W.
REQ-021 SHALL have port stall  out  1: combinational; requested operation not performed this cycle.
REQ-022 SHALL have port pulled  out  1: one-cycle pulse, OSR loaded from FIFO.

Function
REQ-023 SHALL accept a write when wr_valid and wr_ready; wr_ready = (fifo_level < DEPTH); writes are visible for pop from the next cycle (no fall-through).
REQ-024 SHALL apply one OSR operation per cycle, priority mov_en > pull_req > autopull refill > shift_en.
REQ-025 mov_en SHALL load osr <= mov_in and set shift_counter <= 0.
REQ-026 pull_req with FIFO non-empty SHALL pop the head into osr, set shift_counter <= 0, assert pulled.
REQ-027 pull_req with FIFO empty and pull_block=1 SHALL assert stall and leave all state unchanged.
REQ-028 pull_req with FIFO empty and pull_block=0 SHALL load osr <= mov_in and set shift_counter <= 0, pulled low.
REQ-029 Autopull refill SHALL occur when autopull=1, shift_counter >= threshold and FIFO non-empty, whether or not shift_en is high: pop to osr, counter <= 0, pulled=1.
REQ-030 shift_en when autopull=1 and shift_counter >= threshold SHALL not shift; stall=1 that cycle (refill or empty FIFO); the requester holds shift_en.
REQ-031 A right shift by n SHALL set data_out <= osr[n-1:0], osr <= osr >> n.
REQ-032 A left shift by n SHALL set data_out <= osr[DATA_W-1 -: n], osr <= osr << n.
REQ-033 A shift SHALL set shift_counter <= min(shift_counter + n, DATA_W); saturates, never wraps.
REQ-034 data_out SHALL hold its value on non-shift cycles.

Reset
REQ-035 rst SHALL set FIFO empty (fifo_level 0), osr 0, data_out 0, shift_counter DATA_W (OSR empty), pulled 0.
REQ-036 rst mid-operation SHALL discard any write or pop in that cycle; wr_ready is 1 the cycle after.

Structure
REQ-037 Shift-direction constants and DATA_W/DEPTH defaults SHALL live in shared package pio_pkg.
REQ-038 FIFO storage SHALL be a separate sub-module sync_fifo (parametrised width/depth, push/pop/level).

Verification (DATA_W=32, DEPTH=4)
REQ-039 Reset; write 0xDEADBEEF, autopull=1, pull_thresh=0 -> pulled pulses 1 cycle after acceptance; osr=0xDEADBEEF, shift_counter=0.
REQ-040 Right shifts by 8 from 0xDEADBEEF -> data_out 0xEF, osr 0x00DEADBE, counter 8; after 4 shifts counter 32.
REQ-041 mov_in 0x12345678, mov_en, then left shift shift_count=0 -> data_out 0x12345678, osr 0, counter 32.
REQ-042 Four writes, no pops -> fifo_level 4, wr_ready 0; fifth write held until one pop.
REQ-043 Empty FIFO, pull_req, pull_block=1 -> stall=1, osr unchanged; write 0xA5 -> pull completes next cycle, osr=0xA5.
REQ-044 autopull=1, pull_thresh=16, counter 16, FIFO empty, shift_en -> stall=1, osr and counter unchanged.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants and types for the OSR/FIFO block.
package pio_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

  // Shift direction as seen on the shiftdir port.
  typedef enum logic {
    SHIFT_LEFT  = 1'b0,  // MSB first
    SHIFT_RIGHT = 1'b1   // LSB first
  } shift_dir_e;

  // The single OSR operation selected for a cycle.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_MOV   = 2'd1,  // load from mov_in (mov_en or non-blocking empty pull)
    OP_POP   = 2'd2,  // load from FIFO head
    OP_SHIFT = 2'd3
  } osr_op_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, head visible combinationally on rd_data.
// A write becomes poppable only from the following cycle (level counts it then).
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign do_push = push && (level < (AW+1)'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign rd_data = mem[rptr];

  // Storage: no reset needed, but a write during reset is discarded.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/osr_fifo.sv
// Output shift register fed by a small TX FIFO, with explicit/auto pull and mov.
module osr_fifo
  import pio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [$clog2(DEPTH):0]      fifo_level,
  input  logic                        shift_en,
  input  logic [$clog2(DATA_W)-1:0]   shift_count,
  input  logic                        shiftdir,
  input  logic                        autopull,
  input  logic [$clog2(DATA_W)-1:0]   pull_thresh,
  input  logic                        pull_req,
  input  logic                        pull_block,
  input  logic                        mov_en,
  input  logic [DATA_W-1:0]           mov_in,
  output logic [DATA_W-1:0]           data_out,
  output logic [DATA_W-1:0]           osr,
  output logic [$clog2(DATA_W):0]     shift_counter,
  output logic                        stall,
  output logic                        pulled
);
  localparam int CW = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [CW-1:0]     n, thresh;
  logic              refill_due;
  osr_op_e           op;
  shift_dir_e        dir;
  logic [DATA_W-1:0] sh_osr, sh_out;
  logic [CW:0]       cnt_sum;
  logic [CW-1:0]     cnt_sat;

  assign wr_ready   = fifo_level < CW'(0) + ($clog2(DEPTH)+1)'(DEPTH);
  assign fifo_empty = (fifo_level == '0);
  assign dir        = shift_dir_e'(shiftdir);

  // A zero count/threshold encodes a full word.
  assign n          = (shift_count == '0) ? CW'(DATA_W) : CW'(shift_count);
  assign thresh     = (pull_thresh == '0) ? CW'(DATA_W) : CW'(pull_thresh);
  assign refill_due = autopull && (shift_counter >= thresh);

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_valid && wr_ready),
    .pop     (op == OP_POP),
    .wr_data (wr_data),
    .rd_data (fifo_head),
    .level   (fifo_level)
  );

  // Pick one OSR operation by priority; flag requests that cannot proceed.
  always_comb begin
    op    = OP_NONE;
    stall = 1'b0;
    if (mov_en) begin
      op = OP_MOV;
    end else if (pull_req) begin
      if (!fifo_empty)     op    = OP_POP;
      else if (pull_block) stall = 1'b1;
      else                 op    = OP_MOV;
    end else if (refill_due && !fifo_empty) begin
      // A pending shift waits for the refill and retries next cycle.
      op    = OP_POP;
      stall = shift_en;
    end else if (shift_en) begin
      if (refill_due) stall = 1'b1;
      else            op    = OP_SHIFT;
    end
  end

  // Shift datapath; shifting by DATA_W yields zero, and the mask becomes all ones.
  always_comb begin
    if (dir == SHIFT_RIGHT) begin
      sh_osr = osr >> n;
      sh_out = osr & ~({DATA_W{1'b1}} << n);
    end else begin
      sh_osr = osr << n;
      sh_out = osr >> (CW'(DATA_W) - n);
    end
    cnt_sum = {1'b0, shift_counter} + {1'b0, n};
    cnt_sat = (cnt_sum > (CW+1)'(DATA_W)) ? CW'(DATA_W) : cnt_sum[CW-1:0];
  end

  // OSR state update; after reset the OSR reads as fully consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      osr           <= '0;
      data_out      <= '0;
      shift_counter <= CW'(DATA_W);
      pulled        <= 1'b0;
    end else begin
      pulled <= (op == OP_POP);
      unique case (op)
        OP_MOV: begin
          osr           <= mov_in;
          shift_counter <= '0;
        end
        OP_POP: begin
          osr           <= fifo_head;
          shift_counter <= '0;
        end
        OP_SHIFT: begin
          osr           <= sh_osr;
          data_out      <= sh_out;
          shift_counter <= cnt_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osr_fifo.sv
// Bench for osr_fifo (DATA_W=32, DEPTH=4): directed scenarios then random traffic,
// compared cycle by cycle against a queue-based arithmetic model.
module tb_osr_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  fifo_level;
  logic        shift_en;
  logic [4:0]  shift_count;
  logic        shiftdir;
  logic        autopull;
  logic [4:0]  pull_thresh;
  logic        pull_req;
  logic        pull_block;
  logic        mov_en;
  logic [31:0] mov_in;
  logic [31:0] data_out;
  logic [31:0] osr;
  logic [5:0]  shift_counter;
  logic        stall;
  logic        pulled;

  osr_fifo #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .fifo_level(fifo_level), .shift_en(shift_en), .shift_count(shift_count),
    .shiftdir(shiftdir), .autopull(autopull), .pull_thresh(pull_thresh),
    .pull_req(pull_req), .pull_block(pull_block), .mov_en(mov_en), .mov_in(mov_in),
    .data_out(data_out), .osr(osr), .shift_counter(shift_counter), .stall(stall),
    .pulled(pulled)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [31:0]     q[$];
  longint unsigned m_osr, m_dout;
  int              m_cnt;
  bit              m_pulled;
  logic            obs_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pow2(input int k);
    longint unsigned p = 1;
    repeat (k) p = p * 2;
    return p;
  endfunction

  task automatic clear_inputs();
    rst = 0; wr_data = 0; wr_valid = 0; shift_en = 0; shift_count = 0; shiftdir = 0;
    autopull = 0; pull_thresh = 0; pull_req = 0; pull_block = 0; mov_en = 0; mov_in = 0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    int n, th;
    bit due, empty, accept, exp_stall;
    #2;
    obs_stall = stall;
    n      = (shift_count == 0) ? 32 : int'(shift_count);
    th     = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    empty  = (q.size() == 0);
    due    = autopull && (m_cnt >= th);
    accept = wr_valid && (q.size() < 4);
    exp_stall = 0;
    if (!rst) begin
      m_pulled = 0;
      if (mov_en) begin
        m_osr = mov_in; m_cnt = 0;
      end else if (pull_req) begin
        if (!empty) begin
          m_osr = q.pop_front(); m_cnt = 0; m_pulled = 1;
        end else if (pull_block) exp_stall = 1;
        else begin
          m_osr = mov_in; m_cnt = 0;
        end
      end else if (due && !empty) begin
        m_osr = q.pop_front(); m_cnt = 0; m_pulled = 1; exp_stall = shift_en;
      end else if (shift_en) begin
        if (due) exp_stall = 1;
        else begin
          if (shiftdir) begin
            m_dout = m_osr % pow2(n);
            m_osr  = m_osr / pow2(n);
          end else begin
            m_dout = m_osr / pow2(32 - n);
            m_osr  = (m_osr * pow2(n)) % pow2(32);
          end
          m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
        end
      end
      chk("stall", obs_stall, exp_stall);
      chk("wr_ready", wr_ready, (q.size() + (m_pulled ? 1 : 0)) < 4 || !empty && 0 ? 1'b1 : ((q.size() + (m_pulled ? 1 : 0)) < 4));
      if (accept) q.push_back(wr_data);
    end else begin
      q.delete(); m_osr = 0; m_dout = 0; m_cnt = 32; m_pulled = 0;
    end
    @(posedge clk);
    #1;
    chk("osr", osr, m_osr);
    chk("data_out", data_out, m_dout);
    chk("shift_counter", shift_counter, m_cnt);
    chk("pulled", pulled, m_pulled);
    chk("fifo_level", fifo_level, q.size());
  endtask

  initial begin
    clear_inputs();
    q.delete(); m_osr = 0; m_dout = 0; m_cnt = 32; m_pulled = 0;

    // Reset state
    rst = 1; tick(); rst = 0;
    chk("rst_counter", shift_counter, 32);
    chk("rst_wr_ready", wr_ready, 1);

    // First write, autopull at full-word threshold refills the OSR
    wr_valid = 1; wr_data = 32'hDEADBEEF; autopull = 1; pull_thresh = 0; tick();
    wr_valid = 0; tick();
    chk("ap_pulled", pulled, 1);
    chk("ap_osr", osr, 32'hDEADBEEF);
    chk("ap_cnt", shift_counter, 0);
    tick();
    chk("ap_pulse_end", pulled, 0);

    // Right shifts by 8
    shift_en = 1; shift_count = 8; shiftdir = 1; tick();
    chk("rs_dout", data_out, 32'hEF);
    chk("rs_osr", osr, 32'h00DEADBE);
    chk("rs_cnt", shift_counter, 8);
    repeat (3) tick();
    chk("rs_cnt_full", shift_counter, 32);

    // mov then full-word left shift
    shift_en = 0; autopull = 0; mov_in = 32'h12345678; mov_en = 1; tick();
    mov_en = 0; shift_en = 1; shift_count = 0; shiftdir = 0; tick();
    chk("ls_dout", data_out, 32'h12345678);
    chk("ls_osr", osr, 0);
    chk("ls_cnt", shift_counter, 32);
    shift_en = 0;

    // Fill FIFO; fifth write waits for a pop
    wr_valid = 1;
    for (int i = 0; i < 4; i++) begin wr_data = 32'h100 + i; tick(); end
    chk("full_level", fifo_level, 4);
    wr_data = 32'h55; tick();
    chk("full_held", fifo_level, 4);
    pull_req = 1; tick(); pull_req = 0; tick();
    wr_valid = 0;
    chk("full_osr", osr, 32'h100);
    pull_req = 1; repeat (4) tick();
    chk("drain_osr", osr, 32'h55);

    // Blocking pull on empty FIFO
    pull_block = 1; tick();
    chk("blk_stall", obs_stall, 1);
    chk("blk_osr", osr, 32'h55);
    wr_valid = 1; wr_data = 32'hA5; tick(); wr_valid = 0; tick();
    chk("blk_osr_done", osr, 32'hA5);
    pull_req = 0; pull_block = 0;

    // Autopull threshold reached with empty FIFO
    autopull = 1; pull_thresh = 16; shift_en = 1; shift_count = 16; shiftdir = 1; tick();
    chk("thr_cnt", shift_counter, 16);
    tick();
    chk("thr_stall", obs_stall, 1);
    chk("thr_cnt_hold", shift_counter, 16);
    chk("thr_osr_hold", osr, 32'h0);

    // Reset mid-operation discards write and pop
    wr_valid = 1; wr_data = 32'h77; pull_req = 1; tick();
    rst = 1; tick(); rst = 0; wr_valid = 0; pull_req = 0; shift_en = 0;
    tick();
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_ready", wr_ready, 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(99) == 0);
      wr_valid    = ($urandom_range(1) == 1);
      wr_data     = $urandom;
      shift_en    = ($urandom_range(9) < 6);
      shift_count = 5'($urandom_range(31));
      shiftdir    = 1'($urandom_range(1));
      autopull    = ($urandom_range(1) == 1);
      pull_thresh = 5'($urandom_range(31));
      pull_req    = ($urandom_range(9) < 2);
      pull_block  = 1'($urandom_range(1));
      mov_en      = ($urandom_range(19) == 0);
      mov_in      = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard bound on simulation time in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
